// File: rtl/serial_adder_pkg.sv
// Shared types and default constants for the serial adder slice.
package serial_adder_pkg;

  localparam int unsigned SERIAL_ADDER_WIDTH_DEF = 8;
  localparam int unsigned SERIAL_ADDER_BPC_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } serial_adder_state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder built from gate primitives (2 XOR, 2 AND, 1 OR).
module full_adder_cell
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic axb;
  logic gen;
  logic prop;

  xor u_x1 (axb, a, b);
  xor u_x2 (s, axb, cin);
  and u_a1 (gen, a, b);
  and u_a2 (prop, axb, cin);
  or  u_o1 (cout, gen, prop);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle unsigned adder: BITS_PER_CYCLE bits per clock, LSB first,
// valid/ready handshakes on operands and result.
// Optional subtract mode and signed-overflow flag: define SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH          = SERIAL_ADDER_WIDTH_DEF,
  parameter int unsigned BITS_PER_CYCLE = SERIAL_ADDER_BPC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  if ((WIDTH < 1) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be a non-zero multiple of BITS_PER_CYCLE");
  end

  serial_adder_state_t state, state_nxt;

  logic [WIDTH-1:0]          a_sh;
  logic [WIDTH-1:0]          b_sh;
  logic [WIDTH-1:0]          sum_sh;
  logic [WIDTH-1:0]          sum_nxt;
  logic [WIDTH-1:0]          cell_ext;
  logic [BITS_PER_CYCLE-1:0] cell_s;
  logic [BITS_PER_CYCLE-1:0] cell_cout;
  logic                      carry_q;
  logic [CNT_W-1:0]          cnt;
  logic                      last_step;
  logic                      accept;

  // Ripple chain of full-adder cells over the low operand bits.
  for (genvar i = 0; i < int'(BITS_PER_CYCLE); i++) begin : g_cell
    logic cin;
    if (i == 0) begin : g_first
      assign cin = carry_q;
    end else begin : g_next
      assign cin = cell_cout[i-1];
    end
    full_adder_cell u_cell (
      .a    (a_sh[i]),
      .b    (b_sh[i]),
      .cin  (cin),
      .s    (cell_s[i]),
      .cout (cell_cout[i])
    );
  end

  // New sum bits enter at the top; after STEPS shifts the LSB group lands at bit 0.
  assign cell_ext  = WIDTH'(cell_s);
  assign sum_nxt   = (sum_sh >> BITS_PER_CYCLE) | (cell_ext << (WIDTH - BITS_PER_CYCLE));
  assign last_step = (cnt == CNT_W'(STEPS - 1));
  assign accept    = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = RUN;
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifting, carry/count registers and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      s       <= '0;
      c       <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_sh    <= a;
        cnt     <= '0;
`ifdef SERIAL_ADDER_SUB_EN
        b_sh    <= sub ? ~b : b;
        carry_q <= sub;
`else
        b_sh    <= b;
        carry_q <= 1'b0;
`endif
      end else if (state == RUN) begin
        a_sh    <= a_sh >> BITS_PER_CYCLE;
        b_sh    <= b_sh >> BITS_PER_CYCLE;
        sum_sh  <= sum_nxt;
        carry_q <= cell_cout[BITS_PER_CYCLE-1];
        cnt     <= cnt + CNT_W'(1);
        if (last_step) begin
          s <= sum_nxt;
          c <= cell_cout[BITS_PER_CYCLE-1];
`ifdef SERIAL_ADDER_SUB_EN
          ovf <= g_cell[BITS_PER_CYCLE-1].cin ^ cell_cout[BITS_PER_CYCLE-1];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (BPC = 1, 4, 8) at WIDTH = 8.
module tb_serial_adder;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid  [N];
  logic       in_ready  [N];
  logic       out_valid [N];
  logic       out_ready [N];
  logic       c         [N];
  logic [7:0] a         [N];
  logic [7:0] b         [N];
  logic [7:0] s         [N];
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub       [N];
  logic       ovf       [N];
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state per instance.
  logic [7:0] exp_s   [N];
  logic       exp_c   [N];
  logic       exp_ovf [N];
  bit         pending [N];
  bit         seen    [N];
  int         acc     [N];
  bit         op_sub  [N];

  function automatic int bpc_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
  endfunction

  function automatic int steps_of(input int i);
    return 8 / bpc_of(i);
  endfunction

  // {ovf, c, s} from plain arithmetic.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input bit sb);
    logic [8:0] r;
    logic       o;
    if (sb) begin
      r[7:0] = x - y;
      r[8]   = (x >= y);
      o      = (x[7] != y[7]) && (r[7] != x[7]);
    end else begin
      r = {1'b0, x} + {1'b0, y};
      o = (x[7] == y[7]) && (r[7] != x[7]);
    end
    return {o, r};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    serial_adder #(
      .WIDTH          (8),
      .BITS_PER_CYCLE ((g == 0) ? 1 : ((g == 1) ? 4 : 8))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub[g]),
      .ovf       (ovf[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .s         (s[g]),
      .c         (c[g])
    );
  end

  task automatic check(input string nm, input int i, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", nm, i, got, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Track accepted operations and completed handshakes at the active edge.
  always @(posedge clk) begin
    logic [9:0] m;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        pending[i] = 1'b0;
      end else begin
        if (out_valid[i] && out_ready[i]) pending[i] = 1'b0;
        if (in_valid[i] && in_ready[i]) begin
          m          = model(a[i], b[i], op_sub[i]);
          exp_s[i]   = m[7:0];
          exp_c[i]   = m[8];
          exp_ovf[i] = m[9];
          pending[i] = 1'b1;
          seen[i]    = 1'b0;
          acc[i]     = cyc;
        end
      end
    end
  end

  // Compare outputs against the model on every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        if (!seen[i]) begin
          check("latency", i, out_valid[i], (cyc - acc[i]) == steps_of(i));
          if (out_valid[i]) seen[i] = 1'b1;
        end
        if (out_valid[i]) begin
          check("sum", i, s[i], exp_s[i]);
          check("carry", i, c[i], exp_c[i]);
`ifdef SERIAL_ADDER_SUB_EN
          check("ovf", i, ovf[i], exp_ovf[i]);
`endif
        end
      end else begin
        check("idle out_valid", i, out_valid[i], 0);
      end
    end
  end

  task automatic start_op(input int i, input logic [7:0] av, input logic [7:0] bv, input bit sb);
    int n = 0;
    while (!in_ready[i] && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready[i]) check("in_ready timeout", i, in_ready[i], 1);
    a[i]        = av;
    b[i]        = bv;
    op_sub[i]   = sb;
`ifdef SERIAL_ADDER_SUB_EN
    sub[i]      = sb;
`endif
    in_valid[i] = 1'b1;
    tick();
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_result(input int i, output logic [7:0] so, output logic co);
    int n = 0;
    while (!out_valid[i] && n < 40) begin
      tick();
      n++;
    end
    check("result timeout", i, out_valid[i], 1);
    so = s[i];
    co = c[i];
  endtask

  task automatic op_lit(input int i, input logic [7:0] av, input logic [7:0] bv, input bit sb,
                        input logic [7:0] es, input logic ec, input logic eo);
    logic [7:0] so;
    logic       co;
    start_op(i, av, bv, sb);
    wait_result(i, so, co);
    check("literal s", i, so, es);
    check("literal c", i, co, ec);
`ifdef SERIAL_ADDER_SUB_EN
    check("literal ovf", i, ovf[i], eo);
`else
    if (eo) check("ovf needs SUB_EN", i, eo, 0);
`endif
    tick();
  endtask

  task automatic op_model(input int i, input logic [7:0] av, input logic [7:0] bv, input bit sb);
    logic [7:0] so;
    logic       co;
    start_op(i, av, bv, sb);
    wait_result(i, so, co);
    tick();
  endtask

  task automatic back_to_back(input int i);
    int t0;
    int t1;
    int n;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!in_ready[i] && n < 40) begin
        tick();
        n++;
      end
      t1 = cyc;
      if (k > 0) check("b2b period", i, t1 - t0, steps_of(i) + 2);
      t0 = t1;
      if (k < 2) begin
        a[i]        = 8'(8'h21 * (k + 1));
        b[i]        = 8'h0F;
        op_sub[i]   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub[i]      = 1'b0;
`endif
        in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] vec_a [5];
    logic [7:0] vec_b [5];
    logic [7:0] so;
    logic       co;
    vec_a = '{8'h00, 8'h80, 8'hFF, 8'h5A, 8'h13};
    vec_b = '{8'h00, 8'h80, 8'hFF, 8'hA5, 8'h07};

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      a[i]         = '0;
      b[i]         = '0;
      op_sub[i]    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub[i]       = 1'b0;
`endif
    end

    // Reset state.
    repeat (2) tick();
    for (int i = 0; i < N; i++) begin
      check("reset in_ready", i, in_ready[i], 0);
      check("reset out_valid", i, out_valid[i], 0);
      check("reset s", i, s[i], 0);
      check("reset c", i, c[i], 0);
`ifdef SERIAL_ADDER_SUB_EN
      check("reset ovf", i, ovf[i], 0);
`endif
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) check("in_ready after reset", i, in_ready[i], 1);

    // Full carry ripple, BPC = 1.
    op_lit(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

    // BPC = 4 with back-pressure held for 5 cycles.
    out_ready[1] = 1'b0;
    start_op(1, 8'h3C, 8'h45, 1'b0);
    wait_result(1, so, co);
    check("hold s", 1, so, 8'h81);
    check("hold c", 1, co, 0);
    repeat (5) begin
      tick();
      check("hold out_valid", 1, out_valid[1], 1);
      check("hold in_ready", 1, in_ready[1], 0);
      check("hold s", 1, s[1], 8'h81);
      check("hold c", 1, c[1], 0);
    end
    out_ready[1] = 1'b1;
    tick();
    check("released out_valid", 1, out_valid[1], 0);
    check("kept s", 1, s[1], 8'h81);

    // Reset during the 3rd RUN cycle of 0xAA + 0x55.
    start_op(0, 8'hAA, 8'h55, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("in_ready during rst", 0, in_ready[0], 0);
    tick();
    check("abort out_valid", 0, out_valid[0], 0);
    check("abort s", 0, s[0], 0);
    check("abort c", 0, c[0], 0);
    rst = 1'b0;
    #1;
    check("abort in_ready", 0, in_ready[0], 1);
    op_lit(0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Operand offered during RUN must be ignored.
    start_op(0, 8'h12, 8'h34, 1'b0);
    tick();
    a[0]        = 8'h10;
    b[0]        = 8'h10;
    in_valid[0] = 1'b1;
    #1;
    check("in_ready in RUN", 0, in_ready[0], 0);
    tick();
    in_valid[0] = 1'b0;
    wait_result(0, so, co);
    check("ignored s", 0, so, 8'h46);
    check("ignored c", 0, co, 0);
    tick();

    // Degenerate BPC = WIDTH.
    op_lit(2, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0);

    // Throughput with out_ready held high.
    back_to_back(0);
    back_to_back(1);
    back_to_back(2);

    // Model-checked sweep on every instance.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 5; k++)
        op_model(i, vec_a[k], vec_b[k], 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op_lit(0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    op_lit(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    op_lit(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op_lit(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    op_lit(2, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 5; k++)
        op_model(i, vec_a[k], vec_b[4-k], 1'b1);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
